// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md_pkg
// Description : Shared encodings for the E-stage MD issue controller: the
//               MD instruction class, the MD operation select, the E-result
//               mux select, controller states and default MD latencies.
// Revision    : 1.0 - initial release
// ============================================================================
package md_pkg;

   // MD instruction class presented with the E-stage instruction
   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_t;

   // Operation select driven into the MD unit
   localparam logic [1:0] MDOP_MULT  = 2'b00;
   localparam logic [1:0] MDOP_MULTU = 2'b01;
   localparam logic [1:0] MDOP_DIV   = 2'b10;
   localparam logic [1:0] MDOP_DIVU  = 2'b11;

   // E-stage result mux select
   localparam logic [1:0] MF_SEL_ALU = 2'b00;
   localparam logic [1:0] MF_SEL_HI  = 2'b01;
   localparam logic [1:0] MF_SEL_LO  = 2'b10;

   // Default MD latencies (busy cycles after start)
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Controller state: IDLE means the shadow counter is zero
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_t;

   // True for the classes that launch a multiply or divide
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for any real MD class (1..8); everything else behaves as NONE
   function automatic logic is_md_class(input logic [3:0] op);
      return (op >= 4'd1) && (op <= 4'd8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_issue_ctrl
// Description : E-stage controller in front of the multiply/divide unit.
//               Decodes the MD class, issues start/MDOp/mthi/mtlo, selects
//               hi/lo for mfhi/mflo, stalls MD instructions while MD is
//               busy and cross-checks MD busy against a shadow counter.
// Revision    : 1.0 - initial release
// ============================================================================
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_E,
   input  logic [3:0]  md_op_E,
   input  logic [31:0] rs_E,
   input  logic [31:0] rt_E,
   input  logic        md_busy,
   output logic [31:0] A,
   output logic [31:0] B,
   output logic [31:0] WD,
   output logic        start,
   output logic [1:0]  MDOp,
   output logic        mthi,
   output logic        mtlo,
   output logic        stall,
   output logic [1:0]  mf_sel,
   output logic        sync_err
);

   // Counter width is tied to the longest latency
   localparam int CW = $clog2(DIV_CYCLES + 1);

   md_state_t   state;
   logic [CW-1:0] cnt;

   logic md_act;
   logic issue_ok;
   logic op_is_div;

   // Operands go straight through to MD; they are always valid
   assign A  = rs_E;
   assign B  = rt_E;
   assign WD = rs_E;

   // Decode and issue; everything except the operand pass-through is held
   // low while reset is asserted so MD sees no spurious requests
   always_comb begin
      md_act    = valid_E && is_md_class(md_op_E);
      op_is_div = (md_op_E == MD_DIV) || (md_op_E == MD_DIVU);
      stall     = md_act && (state == ST_BUSY) && !reset;
      issue_ok  = valid_E && !stall && !reset;

      start = issue_ok && (state == ST_IDLE) && is_muldiv(md_op_E);
      mthi  = issue_ok && (md_op_E == MD_MTHI);
      mtlo  = issue_ok && (md_op_E == MD_MTLO);

      MDOp = MDOP_MULT;
      if (!reset) begin
         case (md_op_E)
            MD_MULTU: MDOp = MDOP_MULTU;
            MD_DIV:   MDOp = MDOP_DIV;
            MD_DIVU:  MDOp = MDOP_DIVU;
            default:  MDOp = MDOP_MULT;
         endcase
      end

      mf_sel = MF_SEL_ALU;
      if (issue_ok) begin
         if (md_op_E == MD_MFHI)
            mf_sel = MF_SEL_HI;
         else if (md_op_E == MD_MFLO)
            mf_sel = MF_SEL_LO;
      end
   end

   // Shadow latency counter, state and sticky busy-mismatch flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         sync_err <= 1'b0;
      end else begin
         if (md_busy != (state == ST_BUSY))
            sync_err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (start) begin
                  cnt   <= op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CW'(1);
               // Last busy cycle: the next cycle is the first free one
               if (cnt == CW'(1))
                  state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_md_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_md_issue_ctrl
// Description : Directed self-checking bench for md_issue_ctrl with a
//               behavioural MD busy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_md_issue_ctrl;

   logic        clk;
   logic        reset;
   logic        valid_E;
   logic [3:0]  md_op_E;
   logic [31:0] rs_E;
   logic [31:0] rt_E;
   logic        md_busy;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] WD;
   logic        start;
   logic [1:0]  MDOp;
   logic        mthi;
   logic        mtlo;
   logic        stall;
   logic [1:0]  mf_sel;
   logic        sync_err;

   int n_assert;
   int n_fail;

   // MD model: busy from the cycle after start for 5 (mult) or 10 (div) cycles
   logic [3:0] md_cnt;
   logic       force_lo;

   md_issue_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .valid_E  (valid_E),
      .md_op_E  (md_op_E),
      .rs_E     (rs_E),
      .rt_E     (rt_E),
      .md_busy  (md_busy),
      .A        (A),
      .B        (B),
      .WD       (WD),
      .start    (start),
      .MDOp     (MDOp),
      .mthi     (mthi),
      .mtlo     (mtlo),
      .stall    (stall),
      .mf_sel   (mf_sel),
      .sync_err (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         md_cnt <= 4'd0;
      else if (start)
         md_cnt <= MDOp[1] ? 4'd10 : 4'd5;
      else if (md_cnt != 4'd0)
         md_cnt <= md_cnt - 4'd1;
   end

   assign md_busy = (md_cnt != 4'd0) && !force_lo;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change 1 time unit after the rising edge
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Apply E-stage inputs and let combinational outputs settle
   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      valid_E = v;
      md_op_E = op;
      rs_E    = rs;
      rt_E    = rt;
      #1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      force_lo = 1'b0;
      reset    = 1'b1;
      drive(1'b1, 4'd1, 32'h0, 32'h0);

      // Reset state: issue outputs held low even with a MULT in E
      next();
      chk("rst_start", {31'd0, start}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_sync", {31'd0, sync_err}, 32'd0);
      chk("rst_mdop", {30'd0, MDOp}, 32'd0);
      next();
      reset = 1'b0;

      // MULT issue at cycle 0
      drive(1'b1, 4'd1, 32'd100000, 32'd928172);
      chk("mult_start", {31'd0, start}, 32'd1);
      chk("mult_mdop", {30'd0, MDOp}, 32'd0);
      chk("mult_A", A, 32'd100000);
      chk("mult_B", B, 32'd928172);
      chk("mult_stall0", {31'd0, stall}, 32'd0);
      // Cycles 1..5 busy: MFHI blocked, except cycle 3 carries an ALU op
      for (int c = 1; c <= 5; c++) begin
         next();
         if (c == 3) begin
            drive(1'b1, 4'd0, 32'd1, 32'd2);
            chk("nonmd_stall", {31'd0, stall}, 32'd0);
         end else begin
            drive(1'b1, 4'd5, 32'd1, 32'd2);
            chk("mult_busy_stall", {31'd0, stall}, 32'd1);
            chk("mult_busy_mfsel", {30'd0, mf_sel}, 32'd0);
         end
      end
      next();
      chk("mult_idle_stall", {31'd0, stall}, 32'd0);
      chk("mult_idle_mfhi", {30'd0, mf_sel}, 32'd1);
      chk("mult_sync", {31'd0, sync_err}, 32'd0);

      // DIVU then blocked MFLO
      next();
      drive(1'b1, 4'd4, 32'd50, 32'd7);
      chk("divu_start", {31'd0, start}, 32'd1);
      chk("divu_mdop", {30'd0, MDOp}, 32'd3);
      for (int c = 1; c <= 10; c++) begin
         next();
         drive(1'b1, 4'd6, 32'd0, 32'd0);
         chk("mflo_stall", {31'd0, stall}, 32'd1);
         chk("mflo_mfsel_blk", {30'd0, mf_sel}, 32'd0);
      end
      next();
      chk("mflo_free_stall", {31'd0, stall}, 32'd0);
      chk("mflo_mfsel", {30'd0, mf_sel}, 32'd2);
      chk("divu_sync", {31'd0, sync_err}, 32'd0);

      // Back-to-back MULT then DIV
      next();
      drive(1'b1, 4'd1, 32'd3, 32'd4);
      chk("b2b_mult_start", {31'd0, start}, 32'd1);
      for (int c = 1; c <= 5; c++) begin
         next();
         drive(1'b1, 4'd3, 32'd9, 32'd3);
         chk("b2b_div_stall", {31'd0, stall}, 32'd1);
         chk("b2b_div_nostart", {31'd0, start}, 32'd0);
      end
      next();
      chk("b2b_div_start", {31'd0, start}, 32'd1);
      chk("b2b_div_mdop", {30'd0, MDOp}, 32'd2);
      chk("b2b_div_stall0", {31'd0, stall}, 32'd0);
      // Reloaded to 10: MFHI blocked cycles 7..16, free at 17
      for (int c = 7; c <= 16; c++) begin
         next();
         drive(1'b1, 4'd5, 32'd0, 32'd0);
         chk("b2b_reload_stall", {31'd0, stall}, 32'd1);
      end
      next();
      chk("b2b_reload_free", {31'd0, stall}, 32'd0);
      chk("b2b_sync", {31'd0, sync_err}, 32'd0);

      // MTHI / MTLO in IDLE, then bubbles
      next();
      drive(1'b1, 4'd7, 32'hDEADBEEF, 32'd0);
      chk("mthi", {31'd0, mthi}, 32'd1);
      chk("mthi_wd", WD, 32'hDEADBEEF);
      chk("mthi_nomtlo", {31'd0, mtlo}, 32'd0);
      chk("mthi_nostart", {31'd0, start}, 32'd0);
      next();
      drive(1'b1, 4'd8, 32'h12345678, 32'd0);
      chk("mthi_one_cycle", {31'd0, mthi}, 32'd0);
      chk("mtlo", {31'd0, mtlo}, 32'd1);
      next();
      drive(1'b0, 4'd7, 32'd0, 32'd0);
      chk("bubble_mthi", {31'd0, mthi}, 32'd0);
      drive(1'b0, 4'd1, 32'd0, 32'd0);
      chk("bubble_start", {31'd0, start}, 32'd0);
      drive(1'b0, 4'd5, 32'd0, 32'd0);
      chk("bubble_mfsel", {30'd0, mf_sel}, 32'd0);
      drive(1'b1, 4'd12, 32'd0, 32'd0);
      chk("undef_op_start", {31'd0, start}, 32'd0);

      // Busy mismatch: MD busy forced low during cycle 2 of a MULT
      next();
      drive(1'b1, 4'd1, 32'd1, 32'd1);
      chk("mm_start", {31'd0, start}, 32'd1);
      next();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      next();
      force_lo = 1'b1;
      #1;
      chk("mm_sync_before", {31'd0, sync_err}, 32'd0);
      next();
      force_lo = 1'b0;
      #1;
      chk("mm_sync_set", {31'd0, sync_err}, 32'd1);
      for (int c = 0; c < 6; c++) next();
      chk("mm_sync_held", {31'd0, sync_err}, 32'd1);

      // Reset during cycle 3 of a DIV
      drive(1'b1, 4'd3, 32'd100, 32'd5);
      chk("rm_div_start", {31'd0, start}, 32'd1);
      next();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      next();
      next();
      drive(1'b1, 4'd3, 32'd0, 32'd0);
      chk("rm_blocked", {31'd0, stall}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rm_stall", {31'd0, stall}, 32'd0);
      chk("rm_start", {31'd0, start}, 32'd0);
      chk("rm_sync", {31'd0, sync_err}, 32'd0);
      next();
      reset = 1'b0;
      drive(1'b1, 4'd1, 32'd6, 32'd7);
      chk("rm_mult_start", {31'd0, start}, 32'd1);
      chk("rm_mult_mdop", {30'd0, MDOp}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         next();
         drive(1'b0, 4'd0, 32'd0, 32'd0);
      end
      next();
      drive(1'b1, 4'd5, 32'd0, 32'd0);
      chk("rm_mult_busy5", {31'd0, stall}, 32'd1);
      next();
      chk("rm_mult_idle", {31'd0, stall}, 32'd0);
      chk("rm_mult_mfsel", {30'd0, mf_sel}, 32'd1);
      chk("rm_final_sync", {31'd0, sync_err}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
